// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - elastic valid/ready register pipeline with bubble collapse and flush
//
// Moves WIDTH-bit beats through DEPTH register stages. A stage loads from its
// predecessor whenever it is empty or the stage ahead of it is also moving.
// Therefore a stalled output lets the pipeline fill completely before in_ready drops.
//
// Parameters:
//   WIDTH    data width in bits (>= 1)
//   DEPTH    number of register stages (>= 1)
//   RST_VAL  value loaded into every stage data register on reset
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, overrides flush and handshakes
//   flush      synchronous clear of every stage valid, no transfers that cycle
//   din        input beat data
//   in_valid   producer presents din
//   in_ready   pipeline accepts din this cycle (combinational from out_ready, flush)
//   dout       data of the last stage
//   out_valid  last stage holds a valid beat (gated by flush)
//   out_ready  consumer accepts dout this cycle
//   count      occupancy, present only when DFF_PIPE_CNT_EN is defined
//
// Optional feature macro: DFF_PIPE_CNT_EN

module dff_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             dout,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef DFF_PIPE_CNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   count
`endif
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] stg_v;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [WIDTH-1:0] stg_d  [DEPTH];

    // A stage can advance when out_ready is high or any stage from it to the
    // output is empty. This form is the unrolled version of
    // adv[i] = !v[i] || adv[i+1], and it avoids a self-referencing vector.
    always_comb begin : adv_chain
        logic all_full;
        all_full = 1'b1;
        adv      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & v_q[i];
            adv[i]   = out_ready | ~all_full;
        end
    end

    // Incoming beat for each stage: din for stage 0, the predecessor otherwise.
    always_comb begin
        stg_v[0] = in_valid;
        stg_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stg_v[i] = v_q[i-1];
            stg_d[i] = data_q[i-1];
        end
    end

    // Data only loads with a valid incoming beat. A stalled last stage
    // therefore never has its dout disturbed, and flush leaves the data untouched.
    always_comb begin
        v_d = v_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        if (flush) begin
            v_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v_d[i] = stg_v[i];
                    if (stg_v[i]) begin
                        data_d[i] = stg_d[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v_q[DEPTH-1] & ~flush;
    assign dout      = data_q[DEPTH-1];

`ifdef DFF_PIPE_CNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (in_xfer && !out_xfer) begin
            cnt_d = cnt_q + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - self-checking bench for dff_pipe (DEPTH=4, WIDTH=8)
module tb_dff_pipe;

    localparam int         W  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'hC3;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] din;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dout;
    logic       out_valid;
    logic       out_ready;
`ifdef DFF_PIPE_CNT_EN
    logic [$clog2(D+1)-1:0] count;
`endif

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DFF_PIPE_CNT_EN
        ,
        .count     (count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: ordered beats (head = oldest) with their stage positions.
    int         m_pos[$];
    logic [7:0] m_dat[$];
    bit         live = 1'b0;

    logic       s_ov;
    logic       s_ir;
    logic [7:0] s_dout;
    logic [31:0] s_cnt;
    int         cyc = 0;
    logic [7:0] got_d[$];
    int         got_c[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [7:0] d, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
    endtask

    // Compare DUT against the model for this cycle, then advance the model.
    task automatic model();
        int         np[$];
        logic [7:0] nd[$];
        int         prev;
        logic       e_ov;
        logic       e_ir;
        e_ov = 1'b0;
        e_ir = 1'b0;
        np   = m_pos;
        nd   = m_dat;
        if (live) begin
            e_ov = !flush && (m_pos.size() > 0) && (m_pos[0] == D - 1);
            chk("out_valid", 32'(s_ov), 32'(e_ov));
            if (e_ov) chk("dout", 32'(s_dout), 32'(m_dat[0]));
`ifdef DFF_PIPE_CNT_EN
            chk("count", s_cnt, 32'(m_pos.size()));
`endif
            if (e_ov && out_ready) begin
                void'(np.pop_front());
                void'(nd.pop_front());
            end
            // Each beat moves one stage forward unless blocked by the beat ahead.
            prev = D;
            for (int k = 0; k < np.size(); k++) begin
                np[k] = (np[k] + 1 < prev - 1) ? np[k] + 1 : prev - 1;
                prev  = np[k];
            end
            e_ir = !flush && (np.size() == 0 || np[np.size()-1] > 0);
            chk("in_ready", 32'(s_ir), 32'(e_ir));
        end
        if (rst) begin
            m_pos.delete();
            m_dat.delete();
            live = 1'b1;
        end else if (flush) begin
            m_pos.delete();
            m_dat.delete();
        end else if (live) begin
            m_pos = np;
            m_dat = nd;
            if (in_valid && e_ir) begin
                m_pos.push_back(0);
                m_dat.push_back(din);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_ov   = out_valid;
        s_ir   = in_ready;
        s_dout = dout;
`ifdef DFF_PIPE_CNT_EN
        s_cnt  = 32'(count);
`else
        s_cnt  = 32'd0;
`endif
        cyc++;
        if (s_ov && out_ready) begin
            got_d.push_back(s_dout);
            got_c.push_back(cyc);
        end
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n, input int budget);
        int t;
        t = 0;
        while (got_d.size() < n && t < budget) begin
            drive(0, 0, 0, 8'h00, 1);
            tick();
            t++;
        end
        chk("drain_done", 32'(got_d.size()), 32'(n));
    endtask

    initial begin
        int c0;
        int acc;
        int sent;
        logic [31:0] iv_pat;
        logic [31:0] or_pat;

        // Reset with traffic present.
        drive(1, 0, 1, 8'hAA, 0);
        tick();
        tick();
        drive(0, 0, 0, 8'h00, 0);
        tick();
        chk("rst_out_valid", 32'(s_ov), 32'd0);
        chk("rst_in_ready", 32'(s_ir), 32'd1);
        chk("rst_dout", 32'(s_dout), 32'(RV));
`ifdef DFF_PIPE_CNT_EN
        chk("rst_count", s_cnt, 32'd0);
`endif

        // Streaming 1..10 back to back.
        got_d.delete(); got_c.delete();
        c0 = cyc + 1;
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 1, 8'(i), 1);
            tick();
        end
        drain(10, 20);
        if (got_d.size() == 10) begin
            chk("stream_latency", 32'(got_c[0] - c0), 32'd4);
            for (int k = 0; k < 10; k++) begin
                chk("stream_data", 32'(got_d[k]), 32'(k + 1));
                chk("stream_gapless", 32'(got_c[k] - got_c[0]), 32'(k));
            end
        end

        // Backpressure: six beats offered into a stalled pipe.
        got_d.delete(); got_c.delete();
        acc = 0;
        for (int t = 0; t < 6; t++) begin
            drive(0, 0, 1, 8'(11 + acc), 0);
            tick();
            if (s_ir) acc++;
        end
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_in_ready", 32'(s_ir), 32'd0);
        chk("bp_out_valid", 32'(s_ov), 32'd1);
        chk("bp_dout", 32'(s_dout), 32'd11);
        chk("bp_no_output", 32'(got_d.size()), 32'd0);
`ifdef DFF_PIPE_CNT_EN
        chk("bp_count", s_cnt, 32'd4);
`endif
        for (int t = 0; t < 30 && got_d.size() < 6; t++) begin
            if (acc < 6) drive(0, 0, 1, 8'(11 + acc), 1);
            else         drive(0, 0, 0, 8'h00, 1);
            tick();
            if (in_valid && s_ir) acc++;
        end
        chk("bp_out_total", 32'(got_d.size()), 32'd6);
        if (got_d.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("bp_order", 32'(got_d[k]), 32'(11 + k));
                chk("bp_gapless", 32'(got_c[k] - got_c[0]), 32'(k));
            end
        end

        // Bubble collapse under a stalled output.
        got_d.delete(); got_c.delete();
        drive(0, 0, 1, 8'd21, 0); tick();
        drive(0, 0, 0, 8'h00, 0); tick(); tick();
        drive(0, 0, 1, 8'd22, 0); tick();
        drive(0, 0, 0, 8'h00, 0); tick(); tick(); tick();
        chk("bub_out_valid", 32'(s_ov), 32'd1);
        chk("bub_dout", 32'(s_dout), 32'd21);
        chk("bub_in_ready", 32'(s_ir), 32'd1);
`ifdef DFF_PIPE_CNT_EN
        chk("bub_count", s_cnt, 32'd2);
`endif
        drain(2, 10);
        if (got_d.size() == 2) begin
            chk("bub_first", 32'(got_d[0]), 32'd21);
            chk("bub_second", 32'(got_d[1]), 32'd22);
            chk("bub_consecutive", 32'(got_c[1] - got_c[0]), 32'd1);
        end

        // Flush with three beats in flight and the oldest at the output.
        got_d.delete(); got_c.delete();
        drive(0, 0, 1, 8'd31, 1); tick();
        drive(0, 0, 1, 8'd32, 1); tick();
        drive(0, 0, 1, 8'd33, 1); tick();
        drive(0, 0, 0, 8'h00, 1); tick();
        drive(0, 1, 1, 8'h77, 1); tick();
        chk("fl_out_valid_gated", 32'(s_ov), 32'd0);
        chk("fl_in_ready_gated", 32'(s_ir), 32'd0);
        for (int t = 0; t < 6; t++) begin
            drive(0, 0, 0, 8'h00, 1);
            tick();
        end
        chk("fl_nothing_out", 32'(got_d.size()), 32'd0);
        chk("fl_out_valid", 32'(s_ov), 32'd0);
`ifdef DFF_PIPE_CNT_EN
        chk("fl_count", s_cnt, 32'd0);
`endif
        c0 = cyc + 1;
        drive(0, 0, 1, 8'h55, 1); tick();
        drain(1, 10);
        if (got_d.size() == 1) begin
            chk("fl_new_data", 32'(got_d[0]), 32'h55);
            chk("fl_new_latency", 32'(got_c[0] - c0), 32'd4);
        end

        // Reset while full and stalled.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 8'(41 + i), 0);
            tick();
        end
        drive(0, 0, 1, 8'd45, 0); tick();
        chk("rf_full", 32'(s_ir), 32'd0);
        drive(1, 0, 0, 8'h00, 0); tick();
        drive(0, 0, 0, 8'h00, 0); tick();
        chk("rf_out_valid", 32'(s_ov), 32'd0);
        chk("rf_in_ready", 32'(s_ir), 32'd1);
        chk("rf_dout", 32'(s_dout), 32'(RV));
`ifdef DFF_PIPE_CNT_EN
        chk("rf_count", s_cnt, 32'd0);
`endif
        got_d.delete(); got_c.delete();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 8'(51 + i), 1);
            tick();
        end
        drain(4, 10);
        if (got_d.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("rf_after", 32'(got_d[k]), 32'(51 + k));
        end

        // Mixed valid / ready patterns.
        got_d.delete(); got_c.delete();
        iv_pat = 32'hF3B7_6D5E;
        or_pat = 32'h5A3C_C3E1;
        sent = 0;
        for (int t = 0; t < 32; t++) begin
            drive(0, 0, iv_pat[t], 8'(60 + sent), or_pat[t]);
            tick();
            if (in_valid && s_ir) sent++;
        end
        drain(sent, 20);
        for (int k = 0; k < got_d.size(); k++) chk("mix_order", 32'(got_d[k]), 32'(60 + k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
